// File: rtl/ppu_chr_arb_if.sv
//------------------------------------------------------------------------------
// ppu_chr_arb_if : CHR SRAM arbiter bus (cfg port, PPU fetch port, SRAM pins)
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ppu_chr_arb_if;
  logic        i_cfg_req;
  logic        i_cfg_we;
  logic [12:0] i_cfg_addr;
  logic [7:0]  i_cfg_wdata;
  logic        o_cfg_ack;
  logic [7:0]  o_cfg_rdata;
  logic        i_pt_req;
  logic [11:0] i_pt_addr;
  logic        o_pt_ack;
  logic [15:0] o_pt_rdata;
  logic [11:0] o_sram_addr;
  logic [15:0] o_sram_wdata;
  logic        o_sram_dq_oe;
  logic [15:0] i_sram_rdata;
  logic        o_sram_we_n;
  logic        o_sram_oe_n;
  logic        o_sram_ub_n;
  logic        o_sram_lb_n;
  logic        o_busy;

  modport slave (
    input  i_cfg_req, i_cfg_we, i_cfg_addr, i_cfg_wdata,
    output o_cfg_ack, o_cfg_rdata,
    input  i_pt_req, i_pt_addr,
    output o_pt_ack, o_pt_rdata,
    output o_sram_addr, o_sram_wdata, o_sram_dq_oe,
    input  i_sram_rdata,
    output o_sram_we_n, o_sram_oe_n, o_sram_ub_n, o_sram_lb_n,
    output o_busy
  );

  modport master (
    output i_cfg_req, i_cfg_we, i_cfg_addr, i_cfg_wdata,
    input  o_cfg_ack, o_cfg_rdata,
    output i_pt_req, i_pt_addr,
    input  o_pt_ack, o_pt_rdata,
    input  o_sram_addr, o_sram_wdata, o_sram_dq_oe,
    output i_sram_rdata,
    input  o_sram_we_n, o_sram_oe_n, o_sram_ub_n, o_sram_lb_n,
    input  o_busy
  );
endinterface

`default_nettype wire

// File: rtl/ppu_chr_arb.sv
//------------------------------------------------------------------------------
// ppu_chr_arb : shares a 4K x 16 CHR SRAM between a byte-wide cfg port and
//               the PPU pattern fetch port; cfg has fixed priority.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ppu_chr_arb #(
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 2
) (
  input  wire logic       i_ppu_clk,
  input  wire logic       i_ppu_rstn,
  ppu_chr_arb_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_ACK      = 3'd5
  } state_e;

  localparam logic [7:0] RD_LAST = 8'(RD_WAIT);
  localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        own_pt_q;
  logic        lane_q;

  logic [11:0] sram_addr_q;
  logic [15:0] sram_wdata_q;
  logic        dq_oe_q;
  logic        we_n_q;
  logic        oe_n_q;
  logic        ub_n_q;
  logic        lb_n_q;
  logic        cfg_ack_q;
  logic [7:0]  cfg_rdata_q;
  logic        pt_ack_q;
  logic [15:0] pt_rdata_q;
  logic        busy_q;

  // Grant decode for the IDLE cycle: cfg has absolute priority.
  logic        gnt_any_d;
  logic        gnt_we_d;
  logic [11:0] gnt_addr_d;
  logic        gnt_ub_n_d;
  logic        gnt_lb_n_d;

  always_comb begin
    gnt_any_d  = bus.i_cfg_req | bus.i_pt_req;
    gnt_we_d   = bus.i_cfg_req & bus.i_cfg_we;
    gnt_addr_d = bus.i_cfg_req ? bus.i_cfg_addr[12:1] : bus.i_pt_addr;
    gnt_ub_n_d = bus.i_cfg_req ? ~bus.i_cfg_addr[0] : 1'b0;
    gnt_lb_n_d = bus.i_cfg_req ?  bus.i_cfg_addr[0] : 1'b0;
  end

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      own_pt_q     <= 1'b0;
      lane_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      dq_oe_q      <= 1'b0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
      cfg_ack_q    <= 1'b0;
      cfg_rdata_q  <= '0;
      pt_ack_q     <= 1'b0;
      pt_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      cfg_ack_q <= 1'b0;
      pt_ack_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_any_d) begin
            own_pt_q    <= ~bus.i_cfg_req;
            lane_q      <= bus.i_cfg_addr[0];
            sram_addr_q <= gnt_addr_d;
            ub_n_q      <= gnt_ub_n_d;
            lb_n_q      <= gnt_lb_n_d;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            if (gnt_we_d) begin
              sram_wdata_q <= {bus.i_cfg_wdata, bus.i_cfg_wdata};
              dq_oe_q      <= 1'b1;
              state_q      <= S_WR_SETUP;
            end else begin
              oe_n_q  <= 1'b0;
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cnt_q == RD_LAST) begin
            if (own_pt_q) begin
              pt_rdata_q <= bus.i_sram_rdata;
              pt_ack_q   <= 1'b1;
            end else begin
              cfg_rdata_q <= lane_q ? bus.i_sram_rdata[15:8] : bus.i_sram_rdata[7:0];
              cfg_ack_q   <= 1'b1;
            end
            oe_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WR_SETUP: begin
          we_n_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (cnt_q == WR_LAST) begin
            we_n_q  <= 1'b1;
            state_q <= S_WR_HOLD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WR_HOLD: begin
          // Only the cfg port can write, so the ack always goes there.
          dq_oe_q   <= 1'b0;
          ub_n_q    <= 1'b1;
          lb_n_q    <= 1'b1;
          cfg_ack_q <= 1'b1;
          state_q   <= S_ACK;
        end
        S_ACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          we_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_cfg_ack    = cfg_ack_q;
  assign bus.o_cfg_rdata  = cfg_rdata_q;
  assign bus.o_pt_ack     = pt_ack_q;
  assign bus.o_pt_rdata   = pt_rdata_q;
  assign bus.o_sram_addr  = sram_addr_q;
  assign bus.o_sram_wdata = sram_wdata_q;
  assign bus.o_sram_dq_oe = dq_oe_q;
  assign bus.o_sram_we_n  = we_n_q;
  assign bus.o_sram_oe_n  = oe_n_q;
  assign bus.o_sram_ub_n  = ub_n_q;
  assign bus.o_sram_lb_n  = lb_n_q;
  assign bus.o_busy       = busy_q;

endmodule

`default_nettype wire

// File: doc/ppu_chr_arb.md
Name: ppu_chr_arb

Overview:
- Owns the external CHR SRAM (4K x 16) and shares it between two requesters.
  - Configuration port: CPU-side byte reads and writes, used for loading and patching CHR.
  - PPU pattern-table fetch port: 16-bit word reads.
- Serialises accesses, generates SRAM strobe timing and returns data through per-port req/ack handshakes.
- Configuration always wins arbitration. A PPU fetch that collides with configuration traffic is delayed, never corrupted.

Parameters:
- RD_WAIT, 1, extra cycles `o_sram_oe_n` stays low before read data is sampled (read strobe = RD_WAIT+1 cycles).
- WR_PULSE, 2, cycles `o_sram_we_n` stays low per write (min 1).

Ports:
- i_ppu_clk  input  1  block clock
- i_ppu_rstn  input  1  asynchronous active-low reset
- i_cfg_req  input  1  configuration access request, level, held until ack
- i_cfg_we  input  1  1=write, 0=read; sampled at grant
- i_cfg_addr  input  13  byte address; [12:1]=word, [0]=lane (0=low byte)
- i_cfg_wdata  input  8  write byte
- o_cfg_ack  output  1  one-cycle completion pulse
- o_cfg_rdata  output  8  read byte, valid while o_cfg_ack=1, held after
- i_pt_req  input  1  pattern fetch request, level, held until ack
- i_pt_addr  input  12  word address
- o_pt_ack  output  1  one-cycle completion pulse
- o_pt_rdata  output  16  fetched word, valid while o_pt_ack=1, held after
- o_sram_addr  output  12  SRAM word address
- o_sram_wdata  output  16  SRAM write data
- o_sram_dq_oe  output  1  1=drive SRAM data bus
- i_sram_rdata  input  16  SRAM read data
- o_sram_we_n  output  1  write strobe, active low
- o_sram_oe_n  output  1  output enable, active low
- o_sram_ub_n  output  1  upper byte enable, active low
- o_sram_lb_n  output  1  lower byte enable, active low
- o_busy  output  1  1 whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset values:
  - SRAM strobes: we_n=1, oe_n=1, ub_n=1, lb_n=1, dq_oe=0.
  - addr=0, wdata=0.
  - acks=0, rdata=0.
  - busy=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-access immediately forces we_n and oe_n high and dq_oe low, and aborts with no ack.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE:
  - Requests are sampled only in IDLE.
  - If i_cfg_req=1, grant cfg. Else if i_pt_req=1, grant pt. Else stay.
  - At grant, latch owner, we, address, lane and wdata. Later changes on the request inputs are ignored until ACK.
  - Grant to read goes to RD; grant to cfg write goes to WR_SETUP.
- RD:
  - Drive addr, oe_n=0, dq_oe=0.
  - pt: ub_n=lb_n=0. cfg: only the lane selected by addr[0] is enabled.
  - Stay RD_WAIT+1 cycles.
  - On the last cycle, capture i_sram_rdata. pt takes the full word; cfg takes [7:0] if lane 0, else [15:8].
  - Then go to ACK.
- WR_SETUP (1 cycle):
  - Drive addr and wdata = {wdata, wdata}; dq_oe=1, we_n=1.
  - Assert the selected lane enable only.
- WR_PULSE: same drive with we_n=0 for WR_PULSE cycles.
- WR_HOLD (1 cycle): we_n=1, data and dq_oe still driven.
- ACK (1 cycle):
  - All strobes idle, dq_oe=0.
  - Pulse the owner's ack (o_cfg_ack or o_pt_ack); then IDLE.
  - The requester must drop req on the edge ending the ack cycle. A req still high in the following IDLE is treated as a new request.
- Latency from grant cycle (cycle 0) to ack cycle:
  - read: RD_WAIT+2
  - write: WR_PULSE+3
- Simultaneous requests in IDLE: cfg always wins; pt waits. Sustained cfg traffic can starve pt; this is accepted, because configuration during rendering is a software error.
- Only one ack is asserted per cycle, and never both.
- o_sram_we_n and o_sram_oe_n are never low in the same cycle.
- dq_oe is never 1 while oe_n=0.

Test Plan:
- Reset, then idle 10 cycles -> all strobes 1, dq_oe=0, acks 0, busy=0, addr=0.
- cfg write addr=0x0A3 data=0x5C (RD_WAIT=1, WR_PULSE=2):
  - o_sram_addr=0x051, ub_n=0, lb_n=1, wdata=0x5C5C.
  - we_n low exactly cycles 2-3; o_cfg_ack at cycle 5.
- SRAM model word 0x051=0x5C12:
  - cfg read addr=0x0A2 -> lb only, o_cfg_rdata=0x12 with ack at cycle 3.
  - pt read addr=0x051 -> ub_n=lb_n=0, o_pt_rdata=0x5C12 with ack at cycle 3.
- cfg_req and pt_req both rise the same cycle:
  - cfg is served first; pt is granted in the IDLE after cfg's ACK.
  - pt returns correct data; no cycle has both acks high.
- Back-to-back pt_req held high across 4 fetches (addr incrementing after each ack) -> ack every 4 cycles, data matches model each time.
- Assert i_ppu_rstn low during WR_PULSE -> we_n goes 1 asynchronously, no ack, model word unchanged by any partial write; after release, state IDLE.
